// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for a fetch stage.
// It boots from RESET_VECTOR, advances the PC on accepted fetches, and holds
// the PC while stalled or while memory is not ready. A taken branch redirects
// the PC and then inserts FLUSH_CYCLES bubble cycles with Flush asserted.
//
// Ports:
//   CLK              single clock, rising edge
//   RST              synchronous active-high reset
//   BranchValid      branch/jump resolving in execute this cycle
//   BranchComparison branch taken (jumps arrive as 1)
//   BranchTarget     redirect address, used only on a taken branch
//   InstrReady       instruction memory accepts the current PC
//   Stall            hazard stall, hold the PC
//   PC               current fetch address (registered)
//   FetchValid       PC is a valid fetch request (registered)
//   Flush            kill wrong-path instructions (registered)
//   TakenCount       saturating count of taken branches (registered)
//   BranchCount      saturating count of resolved branches (registered)
//
// state    | meaning
// BOOT     | one idle cycle after reset, PC = RESET_VECTOR, no fetch
// FETCH    | issuing fetches; branches, stalls and memory waits act here
// REDIRECT | bubble cycles after a taken branch, Flush = 1, inputs ignored
//
// FLUSH_CYCLES must lie in 1..7; the bubble counter is 3 bits wide.
module pc_sequencer #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [15:0] PC_STEP      = 16'd1,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        BranchValid,
  input  logic        BranchComparison,
  input  logic [15:0] BranchTarget,
  input  logic        InstrReady,
  input  logic        Stall,
  output logic [15:0] PC,
  output logic        FetchValid,
  output logic        Flush,
  output logic [15:0] TakenCount,
  output logic [15:0] BranchCount
);

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    FETCH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  // The counter is loaded with FLUSH_CYCLES-1 and the redirect ends on the
  // cycle it reads zero, giving exactly FLUSH_CYCLES redirect cycles.
  localparam logic [2:0] BUBBLE_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t      state, state_next;
  logic [2:0]  bubble, bubble_next;
  logic [15:0] pc_next, taken_next, branch_next;
  logic        taken;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    pc_next     = PC;
    bubble_next = bubble;
    taken_next  = TakenCount;
    branch_next = BranchCount;
    taken       = 1'b0;
    case (state)
      BOOT: begin
        state_next = FETCH;
      end
      FETCH: begin
        taken = BranchValid && BranchComparison;
        if (BranchValid && (BranchCount != 16'hFFFF)) begin
          branch_next = BranchCount + 16'd1;
        end
        if (taken) begin
          pc_next     = BranchTarget;
          state_next  = REDIRECT;
          bubble_next = BUBBLE_LOAD;
          if (TakenCount != 16'hFFFF) begin
            taken_next = TakenCount + 16'd1;
          end
        end else if (!Stall && InstrReady) begin
          pc_next = PC + PC_STEP;
        end
      end
      REDIRECT: begin
        if (bubble == 3'd0) begin
          state_next = FETCH;
        end else begin
          bubble_next = bubble - 3'd1;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they line up with
  // the state they describe, with no input-to-output combinational path.
  always_ff @(posedge CLK) begin
    if (RST) begin
      PC          <= RESET_VECTOR;
      FetchValid  <= 1'b0;
      Flush       <= 1'b0;
      TakenCount  <= 16'h0000;
      BranchCount <= 16'h0000;
      bubble      <= 3'd0;
    end else begin
      PC          <= pc_next;
      FetchValid  <= (state_next == FETCH);
      Flush       <= (state_next == REDIRECT);
      TakenCount  <= taken_next;
      BranchCount <= branch_next;
      bubble      <= bubble_next;
    end
  end

endmodule
